// File: rtl/target_search_locator_if.sv
// Search-result bus: grayscale pixel stream and arm request in, best-match position out.
// The producer (locator) uses the slave modport; the pixel source / overlay side uses master.
interface target_search_locator_if;
    logic        iDVAL;
    logic [9:0]  iGray;
    logic [12:0] iXposition;
    logic [12:0] iYposition;
    logic [9:0]  iTarget;
    logic        iStart;
    logic [12:0] oXresult;
    logic [12:0] oYresult;
    logic [9:0]  oBestErr;
    logic        oFinished;
    logic        oBusy;

    modport master (
        output iDVAL, iGray, iXposition, iYposition, iTarget, iStart,
        input  oXresult, oYresult, oBestErr, oFinished, oBusy
    );

    modport slave (
        input  iDVAL, iGray, iXposition, iYposition, iTarget, iStart,
        output oXresult, oYresult, oBestErr, oFinished, oBusy
    );
endinterface

// File: rtl/target_search_locator.sv
// Finds the window pixel closest to the armed target intensity over one frame and reports
// its position as an offset from the window middle (input reg -> error -> compare -> DONE).
module target_search_locator #(
    parameter int H_START  = 100,
    parameter int V_START  = 50,
    parameter int SEARCH_W = 64,
    parameter int SEARCH_H = 48
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    target_search_locator_if.slave  search
);

    localparam logic [12:0] X_LO  = 13'(H_START);
    localparam logic [12:0] X_HI  = 13'(H_START + SEARCH_W - 1);
    localparam logic [12:0] Y_LO  = 13'(V_START);
    localparam logic [12:0] Y_HI  = 13'(V_START + SEARCH_H - 1);
    localparam logic [12:0] X_OFF = 13'(H_START + SEARCH_W / 2);
    localparam logic [12:0] Y_OFF = 13'(V_START + SEARCH_H / 2);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, SCAN, DONE} state_t;

    state_t      state;
    logic [9:0]  target;

    logic        r0Valid, r0Last;
    logic [9:0]  r0Gray;
    logic [12:0] r0X, r0Y;

    logic        s1Valid, s1Last;
    logic [9:0]  s1Err;
    logic [12:0] s1X, s1Y;

    logic        s2Last;
    logic        haveBest;
    logic [9:0]  bestErr;
    logic [12:0] bestX, bestY;

    logic        isSof, inWindow, take;
    logic [9:0]  errNext;

    always_comb begin
        isSof    = (search.iXposition == '0) && (search.iYposition == '0);
        inWindow = (search.iXposition >= X_LO) && (search.iXposition <= X_HI) &&
                   (search.iYposition >= Y_LO) && (search.iYposition <= Y_HI);
        // The SOF pixel is sampled on the same edge that enters SCAN.
        take     = search.iDVAL && inWindow &&
                   ((state == SCAN) || ((state == WAIT_SOF) && isSof));
        errNext  = (r0Gray >= target) ? (r0Gray - target) : (target - r0Gray);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state            <= IDLE;
            target           <= '0;
            r0Valid          <= 1'b0;
            r0Last           <= 1'b0;
            r0Gray           <= '0;
            r0X              <= '0;
            r0Y              <= '0;
            s1Valid          <= 1'b0;
            s1Last           <= 1'b0;
            s1Err            <= '0;
            s1X              <= '0;
            s1Y              <= '0;
            s2Last           <= 1'b0;
            haveBest         <= 1'b0;
            bestErr          <= '0;
            bestX            <= '0;
            bestY            <= '0;
            search.oXresult  <= '0;
            search.oYresult  <= '0;
            search.oBestErr  <= '0;
            search.oFinished <= 1'b0;
            search.oBusy     <= 1'b0;
        end else begin
            // Valid-tagged pipeline moves every cycle, so the drain needs no further data.
            r0Valid <= take;
            r0Gray  <= search.iGray;
            r0X     <= search.iXposition;
            r0Y     <= search.iYposition;
            r0Last  <= (search.iXposition == X_HI) && (search.iYposition == Y_HI);

            s1Valid <= r0Valid;
            s1Err   <= errNext;
            s1X     <= r0X;
            s1Y     <= r0Y;
            s1Last  <= r0Last;

            s2Last  <= s1Valid && s1Last;

            // Strict compare: ties keep the earliest pixel in raster order.
            if (s1Valid && (!haveBest || (s1Err < bestErr))) begin
                haveBest <= 1'b1;
                bestErr  <= s1Err;
                bestX    <= s1X;
                bestY    <= s1Y;
            end

            case (state)
                WAIT_SOF: if (search.iDVAL && isSof) state <= SCAN;
                SCAN: begin
                    if (s2Last) begin
                        state            <= DONE;
                        search.oXresult  <= bestX - X_OFF;
                        search.oYresult  <= bestY - Y_OFF;
                        search.oBestErr  <= bestErr;
                        search.oFinished <= 1'b1;
                        search.oBusy     <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (search.iStart) begin
                state            <= WAIT_SOF;
                target           <= search.iTarget;
                r0Valid          <= 1'b0;
                s1Valid          <= 1'b0;
                s2Last           <= 1'b0;
                haveBest         <= 1'b0;
                search.oFinished <= 1'b0;
                search.oBusy     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_target_search_locator.sv
// Self-checking bench for target_search_locator: table-driven directed frames, restart/reset
// sequences and randomized frames scored against a window-scan reference model.
module tb_target_search_locator;

    localparam int H_START  = 100;
    localparam int V_START  = 50;
    localparam int SEARCH_W = 64;
    localparam int SEARCH_H = 48;
    localparam int X_END    = H_START + SEARCH_W - 1;
    localparam int Y_END    = V_START + SEARCH_H - 1;
    // Driven region of each frame: the window plus a margin of out-of-window pixels.
    localparam int FX0 = 90;
    localparam int FX1 = 165;
    localparam int FY0 = 49;
    localparam int FY1 = 98;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    target_search_locator_if ifc();

    target_search_locator #(
        .H_START (H_START),
        .V_START (V_START),
        .SEARCH_W(SEARCH_W),
        .SEARCH_H(SEARCH_H)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst),
        .search(ifc.slave)
    );

    int errors = 0;
    int checks = 0;
    int pix [FX0:FX1][FY0:FY1];

    int   cyc      = 0;
    int   lastEdge = -100;
    int   finEdge  = -200;
    logic prevFin  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge index of the last-window-pixel sample and of the oFinished rise.
    always @(negedge clk) begin
        if (ifc.iDVAL && ifc.iXposition == 13'(X_END) && ifc.iYposition == 13'(Y_END))
            lastEdge <= cyc + 1;
        if (ifc.oFinished && !prevFin)
            finEdge <= cyc;
        prevFin <= ifc.oFinished;
    end

    typedef struct {
        int          base;
        int          target;
        int          ox0, oy0, ov0;
        int          ox1, oy1, ov1;
        logic [12:0] ex;
        logic [12:0] ey;
        logic [9:0]  ee;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drivePix(input int x, input int y, input int g);
        ifc.iDVAL      = 1'b1;
        ifc.iXposition = 13'(x);
        ifc.iYposition = 13'(y);
        ifc.iGray      = 10'(g);
        tick();
    endtask

    task automatic idle(input int n);
        ifc.iDVAL = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulseStart(input int t);
        ifc.iTarget = 10'(t);
        ifc.iStart  = 1'b1;
        tick();
        ifc.iStart  = 1'b0;
        ifc.iTarget = 10'($urandom_range(0, 1023));
    endtask

    task automatic sendRows(input int y0, input int y1, input int gapPct, input bit stopAfterLast);
        for (int y = y0; y <= y1; y++) begin
            for (int x = FX0; x <= FX1; x++) begin
                bit isLast;
                isLast = (x == X_END) && (y == Y_END);
                if (gapPct > 0) begin
                    while (int'($urandom_range(0, 99)) < gapPct) idle(1);
                    if (isLast) idle(3);
                end
                drivePix(x, y, pix[x][y]);
                if (isLast && stopAfterLast) begin
                    ifc.iDVAL = 1'b0;
                    return;
                end
            end
        end
        ifc.iDVAL = 1'b0;
    endtask

    task automatic sendFrame(input int gapPct, input bit stopAfterLast);
        drivePix(0, 0, 777);
        sendRows(FY0, FY1, gapPct, stopAfterLast);
    endtask

    task automatic fill(input int base);
        for (int x = FX0; x <= FX1; x++)
            for (int y = FY0; y <= FY1; y++)
                pix[x][y] = base;
    endtask

    // Reference: minimum |gray - target| over the window, first occurrence in raster order.
    task automatic model(input int t, output logic [12:0] ex, output logic [12:0] ey,
                         output logic [9:0] ee);
        int best, bx, by, e;
        best = -1; bx = 0; by = 0;
        for (int y = V_START; y <= Y_END; y++)
            for (int x = H_START; x <= X_END; x++) begin
                e = pix[x][y] - t;
                if (e < 0) e = -e;
                if (best < 0 || e < best) begin
                    best = e; bx = x; by = y;
                end
            end
        ex = 13'(bx - H_START - SEARCH_W / 2);
        ey = 13'(by - V_START - SEARCH_H / 2);
        ee = 10'(best);
    endtask

    task automatic waitFinished(input string tag);
        int n;
        n = 0;
        while (!ifc.oFinished && n < 20) begin
            tick();
            n++;
        end
        check({tag, ".finished"}, 32'(ifc.oFinished), 32'd1);
    endtask

    task automatic runScored(input string tag, input int t, input int gapPct, input bit stop,
                             input logic [12:0] ex, input logic [12:0] ey, input logic [9:0] ee);
        pulseStart(t);
        check({tag, ".busyArmed"}, 32'(ifc.oBusy), 32'd1);
        check({tag, ".finCleared"}, 32'(ifc.oFinished), 32'd0);
        sendFrame(gapPct, stop);
        waitFinished(tag);
        tick();
        check({tag, ".x"}, 32'(ifc.oXresult), 32'(ex));
        check({tag, ".y"}, 32'(ifc.oYresult), 32'(ey));
        check({tag, ".err"}, 32'(ifc.oBestErr), 32'(ee));
        check({tag, ".latency"}, 32'(finEdge - lastEdge), 32'd3);
        check({tag, ".busyDone"}, 32'(ifc.oBusy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [12:0] ex, ey;
        logic [9:0]  ee;

        tbl[0] = '{500,    0, 120, 60, 0,    -1, -1, 0,    13'h1FF4, 13'h1FF2, 10'd0};
        tbl[1] = '{500,    0, 110, 55, 0,    140, 70, 0,   13'h1FEA, 13'h1FED, 10'd0};
        tbl[2] = '{500,    0,  90, 60, 0,    -1, -1, 0,    13'h1FE0, 13'h1FE8, 10'd500};
        tbl[3] = '{500,  500,  -1, -1, 0,    -1, -1, 0,    13'h1FE0, 13'h1FE8, 10'd0};
        tbl[4] = '{0,   1023, 163, 97, 1023, 99, 50, 1023, 13'h001F, 13'h0017, 10'd0};
        tbl[5] = '{300,  200, 150, 80, 199, 151, 80, 201,  13'h0012, 13'h0006, 10'd1};

        ifc.iDVAL = 1'b0; ifc.iGray = '0; ifc.iXposition = '0; ifc.iYposition = '0;
        ifc.iTarget = '0; ifc.iStart = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset.x", 32'(ifc.oXresult), 32'd0);
        check("reset.y", 32'(ifc.oYresult), 32'd0);
        check("reset.err", 32'(ifc.oBestErr), 32'd0);
        check("reset.finished", 32'(ifc.oFinished), 32'd0);
        check("reset.busy", 32'(ifc.oBusy), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i].base);
            if (tbl[i].ox0 >= 0) pix[tbl[i].ox0][tbl[i].oy0] = tbl[i].ov0;
            if (tbl[i].ox1 >= 0) pix[tbl[i].ox1][tbl[i].oy1] = tbl[i].ov1;
            runScored($sformatf("vec%0d", i), tbl[i].target, 0, 1'b0, tbl[i].ex, tbl[i].ey, tbl[i].ee);
        end

        // iDVAL gaps throughout, a gap right before the last pixel, nothing after it.
        fill(500);
        pix[120][60] = 0;
        runScored("gaps", 0, 20, 1'b1, 13'h1FF4, 13'h1FF2, 10'd0);

        // Restart mid-scan: the partial frame's better pixel must be forgotten.
        fill(500);
        pix[110][55] = 0;
        pulseStart(0);
        drivePix(0, 0, 0);
        sendRows(FY0, 60, 0, 1'b0);
        check("restart.holdX", 32'(ifc.oXresult), 32'h1FF4);
        check("restart.holdY", 32'(ifc.oYresult), 32'h1FF2);
        check("restart.finLow", 32'(ifc.oFinished), 32'd0);
        check("restart.busy", 32'(ifc.oBusy), 32'd1);
        fill(500);
        pix[110][55] = 5;
        pix[130][70] = 0;
        runScored("restart", 0, 0, 1'b0, 13'h1FFE, 13'h1FFC, 10'd0);

        // Reset mid-scan, then a full frame without arming must be ignored.
        fill(500);
        pix[120][60] = 0;
        pulseStart(0);
        drivePix(0, 0, 0);
        sendRows(FY0, 70, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midReset.x", 32'(ifc.oXresult), 32'd0);
        check("midReset.y", 32'(ifc.oYresult), 32'd0);
        check("midReset.err", 32'(ifc.oBestErr), 32'd0);
        check("midReset.finished", 32'(ifc.oFinished), 32'd0);
        check("midReset.busy", 32'(ifc.oBusy), 32'd0);
        sendFrame(0, 1'b0);
        idle(10);
        check("unarmed.finished", 32'(ifc.oFinished), 32'd0);
        check("unarmed.busy", 32'(ifc.oBusy), 32'd0);
        check("unarmed.x", 32'(ifc.oXresult), 32'd0);
        runScored("afterReset", 0, 0, 1'b0, 13'h1FF4, 13'h1FF2, 10'd0);

        for (int r = 0; r < 4; r++) begin
            int t;
            t = int'($urandom_range(0, 1023));
            for (int x = FX0; x <= FX1; x++)
                for (int y = FY0; y <= FY1; y++) begin
                    int v;
                    v = t + int'($urandom_range(0, 80)) - 40;
                    if (v < 0) v = 0;
                    if (v > 1023) v = 1023;
                    pix[x][y] = v;
                end
            model(t, ex, ey, ee);
            runScored($sformatf("rand%0d", r), t, (r == 1) ? 15 : 0, r == 1, ex, ey, ee);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
